acc_normalizer: RTL and testbench

Pipelined normalizer directly downstream of the accumulator adder stage. Consumes the adder's unnormalized sum (exponent plus signed mantissa, one bit wider than the accumulator mantissa) and returns a normalized signed accumulator value. Exponent overflow and underflow are flagged. It is a 2-stage valid/ready pipeline so the adder and normalizer can be retimed separately inside the PE accumulate loop.

---
 rtl/acc_normalizer.sv | 163 ++++++++++++++++
 tb/tb_acc_normalizer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_normalizer.sv
// acc_normalizer
//   Two-stage valid/ready normalizer that sits after the accumulator adder.
//   It takes the adder's unnormalized sum and returns a normalized signed
//   mantissa with its exponent. Exponent overflow and underflow are flagged.
//
//   Stage 1 registers the sum, its redundant-sign-bit count and a zero flag.
//   Stage 2 shifts the mantissa, adjusts the exponent and registers the
//   outputs.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational from out_ready)
//   in_exp, in_mant     unnormalized exponent and signed mantissa (MANT_W+1 bits)
//   out_valid/out_ready downstream handshake
//   out_exp, out_mant   normalized exponent and signed mantissa (MANT_W bits)
//   out_zero            result is exact zero (also set on underflow flush)
//   out_ovf             exponent saturated at all ones
//   out_uf              result flushed to zero by exponent underflow
module acc_normalizer #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W:0]   in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_uf
);

    localparam int SW = $clog2(MANT_W + 1);
    // Wide enough to compare the exponent against the shift amount unsigned.
    localparam int CW = ((EXP_W > SW) ? EXP_W : SW) + 1;

    // Stage 1 state
    logic              s1_valid_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [MANT_W:0]   s1_mant_q;
    logic [SW-1:0]     s1_rsb_q;
    logic              s1_zero_q;

    // Stage 2 (output) state
    logic              s2_valid_q;
    logic [EXP_W-1:0]  out_exp_q;
    logic [MANT_W-1:0] out_mant_q;
    logic              out_zero_q;
    logic              out_ovf_q;
    logic              out_uf_q;

    logic adv1, adv2;

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    // Count the run of bits directly below the sign bit that repeat the sign.
    logic [SW-1:0] rsb_d;
    logic          run;

    always_comb begin
        rsb_d = '0;
        run   = 1'b1;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (run && (in_mant[i] == in_mant[MANT_W]))
                rsb_d = rsb_d + SW'(1);
            else
                run = 1'b0;
        end
    end

    // Stage 2 normalization.
    logic [SW-1:0]     sh;
    logic [MANT_W-1:0] shl;
    logic [CW-1:0]     exp_ext, sh_ext;
    logic [EXP_W-1:0]  exp_d;
    logic [MANT_W-1:0] mant_d;
    logic              zero_d, ovf_d, uf_d;

    always_comb begin
        // sh wraps when rsb is 0; that path does not use it.
        sh      = s1_rsb_q - SW'(1);
        // Only the low MANT_W bits survive the left shift, so the sign bit
        // of the wide mantissa never needs to enter the shifter.
        shl     = s1_mant_q[MANT_W-1:0] << sh;
        exp_ext = CW'(s1_exp_q);
        sh_ext  = CW'(sh);
        exp_d   = '0;
        mant_d  = '0;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        uf_d    = 1'b0;
        if (s1_zero_q) begin
            zero_d = 1'b1;
        end else if (s1_rsb_q == '0) begin
            // Carry into the extra bit: arithmetic shift right by one.
            mant_d = s1_mant_q[MANT_W:1];
            if (&s1_exp_q) begin
                exp_d = s1_exp_q;
                ovf_d = 1'b1;
            end else begin
                exp_d = s1_exp_q + EXP_W'(1);
            end
        end else if (exp_ext < sh_ext) begin
            // Not enough exponent headroom: flush to zero.
            zero_d = 1'b1;
            uf_d   = 1'b1;
        end else begin
            mant_d = shl;
            exp_d  = s1_exp_q - EXP_W'(sh);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s1_rsb_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            out_exp_q  <= '0;
            out_mant_q <= '0;
            out_zero_q <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_uf_q   <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_exp_q  <= in_exp;
                    s1_mant_q <= in_mant;
                    s1_rsb_q  <= rsb_d;
                    s1_zero_q <= (in_mant == '0);
                end
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_exp_q  <= exp_d;
                    out_mant_q <= mant_d;
                    out_zero_q <= zero_d;
                    out_ovf_q  <= ovf_d;
                    out_uf_q   <= uf_d;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_exp   = out_exp_q;
    assign out_mant  = out_mant_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;
    assign out_uf    = out_uf_q;

endmodule

// File: tb/tb_acc_normalizer.sv
// Testbench for acc_normalizer: directed vector table, stall/stream and
// reset sequences, and randomized traffic checked against an arithmetic
// reference model through an in-order scoreboard.
module tb_acc_normalizer;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W:0]   in_mant;
    logic              out_valid;
    logic              out_ready;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic              out_zero;
    logic              out_ovf;
    logic              out_uf;

    acc_normalizer #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exp(out_exp), .out_mant(out_mant),
        .out_zero(out_zero), .out_ovf(out_ovf), .out_uf(out_uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    typedef struct {
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              z, o, u;
    } res_t;

    // Reference model: value-level normalization. Scale the signed sum by
    // powers of two until it lands in the normalized band.
    function automatic res_t model(input logic [EXP_W-1:0] e, input logic [MANT_W:0] m);
        res_t   r;
        longint v;
        longint lo, hi;
        int     k;
        r.exp = '0; r.mant = '0; r.z = 1'b0; r.o = 1'b0; r.u = 1'b0;
        v  = longint'($signed(m));
        hi = longint'(1) << (MANT_W - 1);   // 2^(W-1)
        lo = longint'(1) << (MANT_W - 2);   // 2^(W-2)
        if (v == 0) begin
            r.z = 1'b1;
        end else if (v >= hi || v < -hi) begin
            // Too wide for W signed bits: halve (floor) and bump exponent.
            v = (v >= 0) ? v / 2 : -((-v + 1) / 2);
            r.mant = v[MANT_W-1:0];
            if (int'(e) == (1 << EXP_W) - 1) begin
                r.exp = e; r.o = 1'b1;
            end else begin
                r.exp = EXP_W'(int'(e) + 1);
            end
        end else begin
            k = 0;
            while (!((v >= lo && v < hi) || (v >= -hi && v < -lo))) begin
                v = v * 2;
                k++;
            end
            if (int'(e) < k) begin
                r.z = 1'b1; r.u = 1'b1;
            end else begin
                r.exp  = EXP_W'(int'(e) - k);
                r.mant = v[MANT_W-1:0];
            end
        end
        return r;
    endfunction

    // Scoreboard: push model results on accept, compare/pop on emit.
    res_t q[$];
    res_t f;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_spurious: actual out_valid=1 required no pending result at %0t", $time);
                end else begin
                    f = q[0];
                    chk("sb_mant", 32'(out_mant), 32'(f.mant));
                    chk("sb_exp",  32'(out_exp),  32'(f.exp));
                    chk("sb_flags", {29'd0, out_zero, out_ovf, out_uf}, {29'd0, f.z, f.o, f.u});
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_exp, in_mant));
        end
    end

    typedef struct {
        logic [EXP_W-1:0]  e;
        logic [MANT_W:0]   m;
        logic [EXP_W-1:0]  xe;
        logic [MANT_W-1:0] xm;
        logic              xz, xo, xu;
    } vec_t;

    localparam int NV = 13;
    vec_t tv [NV];

    function automatic logic [MANT_W:0] rnd_mant();
        logic [MANT_W:0] m;
        case ($urandom_range(0, 4))
            0:       m = (MANT_W+1)'($urandom_range(0, 63));
            1:       m = '1 - (MANT_W+1)'($urandom_range(0, 63));
            2:       m = (MANT_W+1)'(1) << $urandom_range(0, MANT_W);
            3:       m = ($urandom_range(0, 3) == 0) ? '0 : '1;
            default: m = (MANT_W+1)'($urandom);
        endcase
        return m;
    endfunction

    function automatic logic [EXP_W-1:0] rnd_exp();
        logic [EXP_W-1:0] e;
        case ($urandom_range(0, 3))
            0:       e = EXP_W'($urandom_range(0, 20));
            1:       e = '1;
            2:       e = '1 - EXP_W'($urandom_range(0, 2));
            default: e = EXP_W'($urandom);
        endcase
        return e;
    endfunction

    int  idx;
    logic acc;

    initial begin
        //         e     m           xe    xm        z     o     u
        tv[0]  = '{8'd10,  17'h04000, 8'd10,  16'h4000, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{8'd11,  17'h08000, 8'd12,  16'h4000, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{8'd3,   17'h10000, 8'd4,   16'h8000, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{8'd20,  17'h00010, 8'd10,  16'h4000, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{8'd5,   17'h00010, 8'd0,   16'h0000, 1'b1, 1'b0, 1'b1};
        tv[5]  = '{8'd10,  17'h00010, 8'd0,   16'h4000, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{8'd50,  17'h00000, 8'd0,   16'h0000, 1'b1, 1'b0, 1'b0};
        tv[7]  = '{8'd255, 17'h08000, 8'd255, 16'h4000, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{8'd100, 17'h1FFFF, 8'd85,  16'h8000, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{8'd0,   17'h0C000, 8'd1,   16'h6000, 1'b0, 1'b0, 1'b0};
        tv[10] = '{8'd7,   17'h1C000, 8'd6,   16'h8000, 1'b0, 1'b0, 1'b0};
        tv[11] = '{8'd15,  17'h1FFFF, 8'd0,   16'h8000, 1'b0, 1'b0, 1'b0};
        tv[12] = '{8'd14,  17'h1FFFF, 8'd0,   16'h0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_exp = '0; in_mant = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", {out_exp, out_mant, out_zero, out_ovf, out_uf}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table: one transaction at a time, latency and value checks.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_exp = tv[i].e; in_mant = tv[i].m;
            @(negedge clk);
            chk("tv_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk("tv_lat1", 32'(out_valid), 32'd0);
            @(negedge clk);
            chk("tv_lat2", 32'(out_valid), 32'd1);
            chk("tv_mant", 32'(out_mant), 32'(tv[i].xm));
            chk("tv_exp",  32'(out_exp),  32'(tv[i].xe));
            chk("tv_flags", {29'd0, out_zero, out_ovf, out_uf}, {29'd0, tv[i].xz, tv[i].xo, tv[i].xu});
        end

        // Stall: downstream blocked, five back-to-back inputs offered.
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1; in_exp = tv[0].e; in_mant = tv[0].m;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 5) begin in_exp = tv[idx].e; in_mant = tv[idx].m; end
                else in_valid = 1'b0;
            end
        end
        chk("stall_accepts", 32'(idx), 32'd2);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stream_rate", 32'(out_valid), 32'd1);
            acc = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 5) begin in_exp = tv[idx].e; in_mant = tv[idx].m; end
                else in_valid = 1'b0;
            end
        end
        chk("stream_accepts", 32'(idx), 32'd5);
        @(negedge clk);
        chk("stream_drained", 32'(out_valid), 32'd0);
        chk("stream_sb_empty", 32'(q.size()), 32'd0);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_exp    = rnd_exp();
            in_mant   = rnd_mant();
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rand_drain", 32'(q.size()), 32'd0);
        chk("rand_idle", 32'(out_valid), 32'd0);

        // Reset with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_exp = tv[1].e; in_mant = tv[1].m;
        @(posedge clk); #1;
        in_exp = tv[2].e; in_mant = tv[2].m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_outputs", {out_exp, out_mant, out_zero, out_ovf, out_uf}, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("mid_rst_no_output", 32'(out_valid), 32'd0);

        // Pipeline keeps working after the reset.
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_exp = tv[3].e; in_mant = tv[3].m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_mant", 32'(out_mant), 32'(tv[3].xm));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("final_sb_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
